// File: rtl/multdiv_exec_unit.sv
// Iterative multiply/divide execution unit.
// One op is accepted per issue handshake. A multiply runs a shift-add
// sequence and a divide runs a restoring sequence, one bit per cycle, on
// operand magnitudes. The sign is applied in the final RUN cycle.
// Every op, including exception cases, produces result_valid exactly
// WIDTH+1 edges after the accepting edge.
//
// Handshakes (valid/ready):
//   issue : an op transfers on a rising edge where issue_valid & issue_ready
//           & !flush. Inputs presented while issue_ready is low are ignored.
//   result: result/result_tag/exception are valid while result_valid is high.
//           They stay stable until an edge where result_ack is high.
//           result_ack without result_valid has no effect.
// reset outranks flush. flush outranks ack and issue.
module multdiv_exec_unit #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_is_div,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             result_valid,
  input  logic             result_ack,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] result_tag,
  output logic             exception,
  output logic [1:0]       dbg_state
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]  MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;

  // Op context captured at issue.
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;       // mult: {partial hi, multiplier/product lo}; div: {remainder, quotient}
  logic [WIDTH-1:0]   op_m;      // multiplicand magnitude (mult) or divisor magnitude (div)
  logic               is_div_q;
  logic               neg_q;     // result must be negated at the end
  logic               div_zero_q;
  logic               div_ovf_q;
  logic [TAG_W-1:0]   tag_q;

  // Issue-side operand preparation.
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // One iteration step.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] step_acc;

  // Final sign fix and exception detection.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     ovf_hi;
  logic               mul_ovf;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_exc;

  assign result_valid = (state == ST_DONE);
  assign dbg_state    = state;

  // State register: reset and flush both return the unit to IDLE.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, issue_ready and the issue-accept strobe.
  always_comb begin
    state_nxt   = state;
    issue_ready = 1'b0;
    accept      = 1'b0;
    case (state)
      ST_IDLE: issue_ready = 1'b1;
      ST_RUN: begin
        if (cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (result_ack) begin
          issue_ready = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    accept = issue_valid & issue_ready & ~flush;
    if (accept) state_nxt = ST_RUN;
  end

  // Operand magnitudes and sign of the eventual result.
  always_comb begin
    a_neg = SIGNED && issue_a[WIDTH-1];
    b_neg = SIGNED && issue_b[WIDTH-1];
    a_mag = a_neg ? -issue_a : issue_a;
    b_mag = b_neg ? -issue_b : issue_b;
  end

  // One shift-add or restoring-divide step on the accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_m} : '0);
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, op_m};
    if (is_div_q) begin
      // A failed trial leaves a shifted remainder below the divisor.
      // Its top bit is therefore zero and can be shifted out.
      step_acc = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign-fixed result and exception flag, used on the last RUN cycle.
  always_comb begin
    prod_s  = neg_q ? -acc : acc;
    ovf_hi  = prod_s[2*WIDTH-1:WIDTH-1];
    mul_ovf = SIGNED ? ~((&ovf_hi) | ~(|ovf_hi)) : (|acc[2*WIDTH-1:WIDTH]);
    quo_s   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    if (is_div_q) begin
      // MIN / -1 gives magnitude 2^(WIDTH-1) with a positive sign.
      // Its bit pattern is already MIN.
      fin_res = div_zero_q ? '0 : quo_s;
      fin_exc = div_zero_q | div_ovf_q;
    end else begin
      fin_res = prod_s[WIDTH-1:0];
      fin_exc = mul_ovf;
    end
  end

  // Datapath: capture on accept, iterate in RUN, publish on the final RUN cycle.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      cnt        <= '0;
      acc        <= '0;
      op_m       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      tag_q      <= '0;
      result     <= '0;
      result_tag <= '0;
      exception  <= 1'b0;
    end else if (accept) begin
      cnt        <= '0;
      acc        <= {{WIDTH{1'b0}}, (issue_is_div ? a_mag : b_mag)};
      op_m       <= issue_is_div ? b_mag : a_mag;
      is_div_q   <= issue_is_div;
      neg_q      <= a_neg ^ b_neg;
      div_zero_q <= issue_is_div && (issue_b == '0);
      div_ovf_q  <= issue_is_div && SIGNED && (issue_a == MIN_W) && (issue_b == '1);
      tag_q      <= issue_tag;
    end else if (state == ST_RUN) begin
      if (cnt == CNT_LAST) begin
        result     <= fin_res;
        result_tag <= tag_q;
        exception  <= fin_exc;
      end else begin
        acc <= step_acc;
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule
